hamming_stream_acc: RTL and testbench
=====================================

HAMMING_STREAM_ACC -- requirements
Module: hamming_stream_acc

Interface
REQ-001 Parameter W, default 5: chunk width in bits per accepted beat; legal range 1..64.
REQ-002 Parameter CHUNKS, default 32: beats per operand pair, so total length is W*CHUNKS bits; legal range 1..4096.
REQ-003 Derived constant OW = $clog2(W*CHUNKS+1): result width; equals 8 at the default parameters.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port start, input, 1: begin a new distance computation; sampled only in IDLE.
REQ-007 Port in_valid, input, 1: x and y carry a valid chunk.
REQ-008 Port x, input, W: chunk of operand A.
REQ-009 Port y, input, W: chunk of operand B.
REQ-010 Port in_ready, output, 1: block accepts a chunk this cycle.
REQ-011 Port o, output, OW: running or final Hamming distance.
REQ-012 Port out_valid, output, 1: o holds the final distance.
REQ-013 Port out_ready, input, 1: consumer accepts the result.
REQ-014 Port busy, output, 1: high in ACCUM and DONE.

Function
REQ-015 FSM states: IDLE, ACCUM, DONE.
REQ-016 IDLE: in_ready=0, out_valid=0; start=1 -> ACCUM next cycle, with the accumulator and beat counter cleared to 0.
REQ-017 ACCUM: in_ready=1; a beat is accepted when in_valid && in_ready.
REQ-018 On acceptance the accumulator adds popcount(x ^ y), zero-extended to OW bits, and the beat counter increments.
REQ-019 in_valid=0 in ACCUM: no change to the accumulator or counter; stalls of any length are legal.
REQ-020 Acceptance of beat CHUNKS-1 moves ACCUM -> DONE; out_valid=1 in the next cycle, with o equal to the final sum (latency 1 cycle from the last beat).
REQ-021 DONE: in_ready=0; o and out_valid are held stable until out_ready=1, then -> IDLE next cycle; out_valid is 0 in IDLE.
REQ-022 start while in ACCUM or DONE is ignored; start is not queued.
REQ-023 o reflects the accumulator register in every state (partial sum during ACCUM); only out_valid qualifies it.
REQ-024 Overflow is impossible by construction (maximum W*CHUNKS fits in OW bits); no saturation logic.
REQ-025 Beat counter width $clog2(CHUNKS) (minimum 1); wraps to 0 on the transition to DONE.
REQ-026 CHUNKS=1: a single accepted beat goes directly ACCUM -> DONE.

Reset
REQ-027 rst=1 at a clock edge: state=IDLE, accumulator=0, counter=0; outputs o=0, out_valid=0, in_ready=0, busy=0.
REQ-028 rst has priority over all other inputs; reset mid-ACCUM or mid-DONE discards the partial or final result.

Configuration
REQ-029 Macro HAMMING_THRESH_EN: when defined, add input thr[OW-1:0] and output match (1 bit).
REQ-030 With HAMMING_THRESH_EN, thr is registered when start is accepted, and match = (o <= registered thr).
REQ-031 With HAMMING_THRESH_EN, match is valid only while out_valid=1 and is 0 otherwise; reset value 0.
REQ-032 Without HAMMING_THRESH_EN, the thr and match ports and their logic are absent; all other behaviour is identical.

Structure
REQ-033 Shared package hamming_pkg holds the FSM state enum type and the clog2-based width helper function.
REQ-034 One sub-module, hamming_popcount (purely combinational, parameter W), produces the clog2(W+1)-bit popcount of x^y.

Verification
REQ-035 Defaults, x=y=5'h15 for all 32 beats -> out_valid with o=0.
REQ-036 Defaults, x=5'h1F, y=5'h00 for all 32 beats -> o=160 (8'hA0).
REQ-037 Defaults, x^y=5'h01 with in_valid deasserted every other cycle -> o=32, out_valid exactly 1 cycle after the 32nd accepted beat.
REQ-038 rst asserted after 10 beats, then a new start with 32 beats of x^y=5'h03 -> o=64, with no residue from the aborted run.
REQ-039 out_ready held low for 5 cycles in DONE -> o and out_valid stable; start pulses in DONE are ignored; IDLE follows the out_ready cycle.
REQ-040 HAMMING_THRESH_EN, thr=100: a run giving distance 96 -> match=1; a run giving 160 -> match=0; match=0 whenever out_valid=0.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared types and width helpers for the streaming Hamming-distance accumulator.
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ceil(log2(n)), but never below 1 so a single-beat counter still has a bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/hamming_popcount.sv
// Combinational popcount of x ^ y for one W-bit chunk.
module hamming_popcount #(
  parameter int W = 5
) (
  input  logic [W-1:0]               x,
  input  logic [W-1:0]               y,
  output logic [$clog2(W+1)-1:0]     cnt
);

  localparam int PW = $clog2(W + 1);

  logic [W-1:0] diff;

  assign diff = x ^ y;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + PW'(diff[i]);
    end
  end

endmodule

// File: rtl/hamming_stream_acc.sv
// Streams CHUNKS beats of W-bit operand pairs and reports their Hamming distance.
// Optional threshold compare (thr/match ports) is enabled by defining HAMMING_THRESH_EN.
module hamming_stream_acc
  import hamming_pkg::*;
#(
  parameter  int W      = 5,
  parameter  int CHUNKS = 32,
  localparam int OW     = $clog2(W * CHUNKS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  output logic          in_ready,
  output logic [OW-1:0] o,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef HAMMING_THRESH_EN
  input  logic [OW-1:0] thr,
  output logic          match,
`endif
  output logic          busy
);

  localparam int              CW   = clog2_min1(CHUNKS);
  localparam int              PW   = $clog2(W + 1);
  localparam logic [CW-1:0]   LAST = CW'(CHUNKS - 1);

  state_t         state;
  state_t         state_nxt;
  logic [OW-1:0]  acc;
  logic [CW-1:0]  beat;
  logic [PW-1:0]  pc;
  logic           start_acc;
  logic           accept;
  logic           last_beat;

  hamming_popcount #(.W(W)) u_popcount (
    .x   (x),
    .y   (y),
    .cnt (pc)
  );

  assign start_acc = (state == IDLE) && start;
  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (beat == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = ACCUM;
      ACCUM:   if (last_beat) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Accumulator stays put outside ACCUM, so o keeps the last result in IDLE too.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      beat <= '0;
    end else if (start_acc) begin
      acc  <= '0;
      beat <= '0;
    end else if (accept) begin
      acc  <= acc + OW'(pc);
      beat <= last_beat ? '0 : beat + 1'b1;
    end
  end

  assign o = acc;

`ifdef HAMMING_THRESH_EN
  logic [OW-1:0] thr_q;

  always_ff @(posedge clk) begin
    if (rst)            thr_q <= '0;
    else if (start_acc) thr_q <= thr;
  end

  assign match = out_valid && (acc <= thr_q);
`endif

endmodule

// File: tb/tb_hamming_stream_acc.sv
// Directed self-checking bench for hamming_stream_acc at default parameters.
module tb_hamming_stream_acc;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [4:0] x;
  logic [4:0] y;
  logic       in_ready;
  logic [7:0] o;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
`ifdef HAMMING_THRESH_EN
  logic [7:0] thr;
  logic       match;
`endif

  int tests = 0;
  int fails = 0;

  hamming_stream_acc #(.W(5), .CHUNKS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .in_ready  (in_ready),
    .o         (o),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef HAMMING_THRESH_EN
    .thr       (thr),
    .match     (match),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input logic [4:0] xv, input logic [4:0] yv, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      x = xv;
      y = yv;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    tests++; if (o !== 8'd0)      begin fails++; $display("FAIL reset_o: got %0d want 0", o); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    step();
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL idle_no_start_busy: got %b want 0", busy); end
  endtask

  task automatic test_zero;
    begin_run();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL zero_in_ready: got %b want 1", in_ready); end
    tests++; if (busy !== 1'b1)     begin fails++; $display("FAIL zero_busy: got %b want 1", busy); end
    feed(5'h15, 5'h15, 31);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL zero_early_valid: got %b want 0", out_valid); end
    feed(5'h15, 5'h15, 1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL zero_out_valid: got %b want 1", out_valid); end
    tests++; if (o !== 8'd0)         begin fails++; $display("FAIL zero_o: got %0d want 0", o); end
    tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL zero_done_in_ready: got %b want 0", in_ready); end
    release_result();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL zero_idle_valid: got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL zero_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_max;
    begin_run();
    tests++; if (o !== 8'd0) begin fails++; $display("FAIL max_cleared_o: got %0d want 0", o); end
    feed(5'h1F, 5'h00, 32);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL max_out_valid: got %b want 1", out_valid); end
    tests++; if (o !== 8'hA0)        begin fails++; $display("FAIL max_o: got %0d want 160", o); end
    release_result();
  endtask

  task automatic test_stall;
    begin_run();
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      x = 5'h01;
      y = 5'h00;
      start = (i == 5);
      step();
      in_valid = 1'b0;
      start = 1'b0;
      if (i == 15) begin
        tests++; if (o !== 8'd16) begin fails++; $display("FAIL stall_partial_o: got %0d want 16", o); end
      end
      if (i < 31) begin
        x = 5'h1F;
        step();
        if (i == 20) begin
          tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_in_ready: got %b want 1", in_ready); end
          tests++; if (o !== 8'd21) begin fails++; $display("FAIL stall_hold_o: got %0d want 21", o); end
        end
        if (i == 30) begin
          tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_early_valid: got %b want 0", out_valid); end
        end
      end
    end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stall_out_valid: got %b want 1", out_valid); end
    tests++; if (o !== 8'd32)        begin fails++; $display("FAIL stall_o: got %0d want 32", o); end
    release_result();
  endtask

  task automatic test_abort;
    begin_run();
    feed(5'h1F, 5'h00, 10);
    tests++; if (o !== 8'd50) begin fails++; $display("FAIL abort_partial_o: got %0d want 50", o); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (o !== 8'd0)        begin fails++; $display("FAIL abort_reset_o: got %0d want 0", o); end
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL abort_reset_busy: got %b want 0", busy); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL abort_reset_in_ready: got %b want 0", in_ready); end
    begin_run();
    feed(5'h03, 5'h00, 31);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL abort_early_valid: got %b want 0", out_valid); end
    feed(5'h03, 5'h00, 1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL abort_out_valid: got %b want 1", out_valid); end
    tests++; if (o !== 8'd64)        begin fails++; $display("FAIL abort_o: got %0d want 64", o); end
    release_result();
  endtask

  task automatic test_hold;
    begin_run();
    feed(5'h01, 5'h00, 32);
    for (int k = 0; k < 5; k++) begin
      out_ready = 1'b0;
      start = (k % 2 == 0);
      in_valid = 1'b1;
      x = 5'h1F;
      y = 5'h00;
      step();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL hold_out_valid[%0d]: got %b want 1", k, out_valid); end
      tests++; if (o !== 8'd32)        begin fails++; $display("FAIL hold_o[%0d]: got %0d want 32", k, o); end
      tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL hold_in_ready[%0d]: got %b want 0", k, in_ready); end
    end
    start = 1'b0;
    in_valid = 1'b0;
    release_result();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL hold_idle_valid: got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL hold_idle_busy: got %b want 0", busy); end
    tests++; if (o !== 8'd32)        begin fails++; $display("FAIL hold_idle_o: got %0d want 32", o); end
    step();
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL hold_no_queued_start: got %b want 0", busy); end
  endtask

`ifdef HAMMING_THRESH_EN
  task automatic test_thresh;
    thr = 8'd100;
    begin_run();
    thr = 8'd0;
    feed(5'h07, 5'h00, 31);
    tests++; if (match !== 1'b0) begin fails++; $display("FAIL thr_match_accum: got %b want 0", match); end
    feed(5'h07, 5'h00, 1);
    tests++; if (o !== 8'd96)    begin fails++; $display("FAIL thr_o96: got %0d want 96", o); end
    tests++; if (match !== 1'b1) begin fails++; $display("FAIL thr_match96: got %b want 1", match); end
    release_result();
    tests++; if (match !== 1'b0) begin fails++; $display("FAIL thr_match_idle: got %b want 0", match); end
    thr = 8'd100;
    begin_run();
    thr = 8'd255;
    feed(5'h1F, 5'h00, 32);
    tests++; if (o !== 8'd160)   begin fails++; $display("FAIL thr_o160: got %0d want 160", o); end
    tests++; if (match !== 1'b0) begin fails++; $display("FAIL thr_match160: got %b want 0", match); end
    release_result();
  endtask
`endif

  initial begin
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
`ifdef HAMMING_THRESH_EN
    thr = '0;
`endif
    test_reset();
    test_zero();
    test_max();
    test_stall();
    test_abort();
    test_hold();
`ifdef HAMMING_THRESH_EN
    test_thresh();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
